ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the architectural fetch PC and issues one word-aligned read per instruction to the instruction memory port.
- Captures the returned word and presents {inst, pc} to decode over a valid/ready handshake.
- Accepts a redirect from execute for jal/branches; a redirect flushes any in-flight fetch.

Parameters:
- ADDR_WIDTH, 64, width of PC and memory address.
- INST_WIDTH, 32, instruction width.
- PC_RST, 64'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  ADDR_WIDTH  new fetch PC.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDR_WIDTH  read address; always equals the current fetch PC.
- imem_rsp_valid  in  1  read data returned (exactly one per accepted request, any latency ≥1).
- imem_rsp_data  in  INST_WIDTH  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_inst  out  INST_WIDTH  instruction.
- out_pc  out  ADDR_WIDTH  PC of out_inst.
- out_fault  out  1  instruction carries fetch fault (misaligned or access error).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=REQ, pc=PC_RST.
  - out_valid=0, out_inst=0, out_pc=0, out_fault=0.
  - imem_req_valid goes high in the first cycle after reset release.
- States:
  - REQ: imem_req_valid=1, addr=pc. On req_ready → WAIT.
  - WAIT: awaiting response. On rsp_valid, register out_inst=rsp_data, out_pc=pc, out_fault=rsp_err → HOLD.
  - HOLD: out_valid=1; outputs stable until out_ready.
    - Handshake, fault=0: pc=pc+4 (wraps modulo 2^ADDR_WIDTH) → REQ.
    - Handshake, fault=1: → STALL.
  - DROP: one outstanding response must be discarded. On rsp_valid, ignore the data → REQ.
  - STALL: no requests, out_valid=0; leave only on redirect.
- Latency: rsp_valid at cycle N → out_valid at N+1. Handshake at N → next req_valid at N+1. Zero-wait memory gives 1 instruction per 3 cycles.
- Redirect (highest priority; any state, same cycle as any other event), pc=redirect_pc, then by state:
  - REQ without req_ready, HOLD, STALL: → REQ. A held instruction is discarded (out_valid low next cycle) even if out_ready was high that cycle.
  - REQ with req_ready, or WAIT without rsp_valid: → DROP.
  - WAIT with rsp_valid: the response is discarded → REQ.
  - DROP: stay in DROP; if rsp_valid that cycle → REQ.
- Misaligned redirect (redirect_pc[1:0]≠0): no memory request is issued. Next cycle, HOLD with out_inst=0, out_pc=redirect_pc, out_fault=1. If a response is outstanding, DROP runs first, then the fault is presented. A misaligned pc is latched via an internal flag.
- Request rules:
  - imem_req_valid, once high, holds with a stable address until req_ready. The only exception is redirect, which may change the address.
  - At most one outstanding request.
- out_valid never depends combinationally on out_ready.
- Asserted error: rsp_valid in REQ or STALL is a protocol violation; the block ignores it.

Test Plan:
- Reset release, memory ready=1, 1-cycle latency returning 0x00000013 → requests at 0x80000000, 0x80000004, 0x80000008; each out_pc matches its request and out_fault=0.
- out_ready held low 5 cycles during HOLD → out_inst/out_pc stable, imem_req_valid=0 throughout, pc advances exactly once after the handshake.
- Redirect to 0x80000100 while in WAIT; stale response 0xDEADBEEF returns 3 cycles later → 0xDEADBEEF never appears on out; next request addr=0x80000100.
- Redirect to 0x80000102 → no memory request; out_valid with out_pc=0x80000102, out_fault=1, out_inst=0. After handshake, no requests until redirect to 0x80000200, which resumes fetch there.
- rsp_err=1 on fetch at 0x80000010 → out_fault=1, out_pc=0x80000010, then STALL.
- rst asserted mid-WAIT → all outputs zero immediately (asynchronous); after release, the first request is at 0x80000000. Redirect and out_ready in the same HOLD cycle → the held instruction is not counted as consumed, and fetch goes to redirect_pc.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode.
// Owns the fetch PC and issues one aligned read at a time to instruction memory.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   redirect_valid/_pc       PC change from execute (jal/branch); flushes in-flight fetch
//   imem_req_valid/ready     read request handshake; imem_req_addr is the fetch PC
//   imem_rsp_valid/data/err  read response (one per accepted request, latency >= 1)
//   out_valid/ready          handshake to decode
//   out_inst/out_pc          fetched word and its PC
//   out_fault                fetch fault (misaligned PC or access error)
module ifu_fetch #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RST = 'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_STALL
    } state_e;

    state_e                  state;
    state_e                  stateNext;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pcNext;
    logic                    misFlag;
    logic                    misNext;
    logic [INST_WIDTH-1:0]   outInstQ;
    logic [ADDR_WIDTH-1:0]   outPcQ;
    logic                    outFaultQ;

    logic                    reqValidInt;
    logic                    reqFire;
    logic                    redirMis;
    logic                    rspOwed;
    logic                    advancePc;
    logic                    capRsp;
    logic                    capMisRedir;
    logic                    capMisDrop;

    // Internal request strobe; the port copy is additionally held low
    // while reset is asserted so the bus sees nothing during reset.
    assign reqValidInt = (state == S_REQ) && !misFlag;
    assign reqFire     = reqValidInt && imem_req_ready;
    assign redirMis    = (redirect_pc[1:0] != 2'b00);

    // A response is still owed to us after this cycle: either a request is
    // being accepted right now, or an accepted one has not come back yet.
    assign rspOwed = ((state == S_REQ) && reqFire)
                  || ((state == S_WAIT) && !imem_rsp_valid)
                  || ((state == S_DROP) && !imem_rsp_valid);

    assign advancePc = !redirect_valid && (state == S_HOLD)
                    && out_ready && !outFaultQ;

    assign capRsp = !redirect_valid && (state == S_WAIT) && imem_rsp_valid;

    // Misaligned target with nothing outstanding: fault is presented at once.
    assign capMisRedir = redirect_valid && !rspOwed && redirMis;

    // Misaligned target that had to wait for a stale response to drain.
    assign capMisDrop = !redirect_valid && (state == S_DROP)
                     && imem_rsp_valid && misFlag;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; redirect overrides every other event.
    always_comb begin
        stateNext = state;
        if (redirect_valid) begin
            if (rspOwed) begin
                stateNext = S_DROP;
            end else if (redirMis) begin
                stateNext = S_HOLD;
            end else begin
                stateNext = S_REQ;
            end
        end else begin
            unique case (state)
                S_REQ: begin
                    if (reqFire) begin
                        stateNext = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        stateNext = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        stateNext = outFaultQ ? S_STALL : S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        stateNext = misFlag ? S_HOLD : S_REQ;
                    end
                end
                S_STALL: begin
                    stateNext = S_STALL;
                end
                default: begin
                    stateNext = S_REQ;
                end
            endcase
        end
    end

    // Output logic; everything decode sees comes from registers.
    always_comb begin
        imem_req_valid = rst && reqValidInt;
        imem_req_addr  = pc;
        out_valid      = (state == S_HOLD);
        out_inst       = outInstQ;
        out_pc         = outPcQ;
        out_fault      = outFaultQ;
    end

    // Fetch PC and misaligned flag
    always_comb begin
        pcNext  = pc;
        misNext = misFlag;
        if (redirect_valid) begin
            pcNext  = redirect_pc;
            misNext = redirMis;
        end else if (advancePc) begin
            pcNext = pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= PC_RST;
            misFlag <= 1'b0;
        end else begin
            pc      <= pcNext;
            misFlag <= misNext;
        end
    end

    // Instruction holding register presented to decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outInstQ  <= '0;
            outPcQ    <= '0;
            outFaultQ <= 1'b0;
        end else if (capRsp) begin
            outInstQ  <= imem_rsp_data;
            outPcQ    <= pc;
            outFaultQ <= imem_rsp_err;
        end else if (capMisRedir) begin
            outInstQ  <= '0;
            outPcQ    <= redirect_pc;
            outFaultQ <= 1'b1;
        end else if (capMisDrop) begin
            outInstQ  <= '0;
            outPcQ    <= pc;
            outFaultQ <= 1'b1;
        end
    end

    // A response with no request outstanding is a memory-side bug.
    rspProtocol: assert property (
        @(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && (state == S_REQ || state == S_STALL))
    );

    // An offered request keeps its address until taken, unless redirected.
    reqStable: assert property (
        @(posedge clk) disable iff (!rst)
        (imem_req_valid && !imem_req_ready && !redirect_valid)
        |=> (imem_req_valid && $stable(imem_req_addr))
    );

endmodule
